lfsr_draw_rng: RTL
==================

Name: lfsr_draw_rng

Overview:
- Parametrised Fibonacci LFSR random source for the dino game: obstacle/cactus spawning, spacing and variant selection.
- Keeps the free-running, entropy-gated stepping of the 5-bit cactus generator.
- Adds:
  - configurable width and taps;
  - runtime seed loading with zero-seed protection;
  - a request/valid "draw" interface that delivers OUT_W freshly shifted bits per request.
- Sits between the game controller (draw requests, seeding from user input timing) and the obstacle scheduler.

Parameters:
- WIDTH, 5: LFSR state width; legal range 3..32.
- TAPS, 5'b10010: feedback mask. Feedback bit = XOR of state bits where the mask is 1. Bit WIDTH-1 must be set.
- SEED, 1: reset/fallback state; must be nonzero.
- OUT_W, 5: bits per draw; legal range 1..WIDTH.

Ports:
- clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- entropy_in  in  1  free-run step enable; honoured only while idle
- seed_load  in  1  load seed_in into state this edge
- seed_in  in  WIDTH  seed value
- draw_req  in  1  request OUT_W fresh bits; honoured only while idle
- draw_busy  out  1  high while a draw is in progress
- draw_valid  out  1  one-cycle pulse: draw_data is new
- draw_data  out  OUT_W  result of the last completed draw; held until the next completion
- state  out  WIDTH  current LFSR state

Behaviour:
- Reset (async, sys_rst high): state=SEED, FSM=IDLE, draw_busy=0, draw_valid=0, draw_data=0, step counter=0.
- Step function:
  - fb = ^(state & TAPS)
  - next = {state[WIDTH-2:0], fb}
  - Defaults from state 1 give the sequence 1, 2, 5, 10, 21, 11, ...
- FSM states: IDLE, DRAW.
- IDLE:
  - entropy_in=1 steps the state once per edge.
  - draw_req=1 at an edge (E0) moves to DRAW, loads counter=OUT_W and sets draw_busy=1.
  - If entropy_in is also high at E0, that step still happens at E0.
- DRAW:
  - State steps on every edge, ignoring entropy_in.
  - Counter decrements on each step.
  - On the edge where the counter goes 1→0 (edge E_OUT_W):
    - draw_data <= next[OUT_W-1:0]
    - draw_valid <= 1
    - draw_busy <= 0
    - FSM -> IDLE
  - Result: draw_valid is high in the cycle after E_OUT_W. Latency from request edge to valid = OUT_W edges.
- draw_valid is high for exactly one cycle; it is cleared on the following edge.
- draw_req while busy is ignored; no queuing.
- A new draw_req may be accepted on the same edge that clears draw_valid, i.e. back-to-back draws.
- seed_load has priority over everything, in any state:
  - state <= (seed_in==0) ? SEED : seed_in
  - Any in-progress draw is aborted: FSM=IDLE, draw_busy=0, counter=0.
  - No draw_valid is generated, and draw_data is unchanged.
  - A draw_req in the same cycle is dropped.
- A zero state is unreachable: reset, seed guard and nonzero taps guarantee this. As a defensive guard, if state==0 the next state is SEED.
- sys_rst asserted mid-draw: immediate return to reset values; no valid pulse.
- All outputs are registered.

Decomposition:
- Package rng_pkg:
  - FSM state enum (IDLE, DRAW);
  - default constants: RNG_DEF_WIDTH=5, RNG_DEF_TAPS=5'b10010, RNG_DEF_SEED=1;
  - maximal-length tap masks for widths 8, 16 and 32.
- Sub-module lfsr_core (WIDTH, TAPS, SEED):
  - contains the state register, the step/load/zero-guard logic and the async reset;
  - inputs: step, load, load_val.
- Top level lfsr_draw_rng: FSM, counter and output registers.

Test Plan:
- Reset, then entropy_in=1 for 5 edges (defaults) -> state 2, 5, 10, 21, 11.
- From state 1, draw_req pulsed one cycle -> draw_busy=1 for 5 cycles. The valid pulse and the data arrive together: draw_valid=1 for one cycle and draw_data=5'b01011 (11). state=11. entropy_in toggling during the draw has no effect.
- seed_load with seed_in=0 -> state=1. seed_load with seed_in=5'd21 -> state=21; the next entropy step gives state 11.
- draw_req, then seed_load=1 with seed_in=9 at the 3rd DRAW edge -> no draw_valid, draw_busy=0, draw_data unchanged, state=9.
- sys_rst asserted asynchronously mid-draw -> state=1, draw_busy=0, draw_valid=0 immediately. draw_req held continuously -> back-to-back draws, draw_valid every 6th cycle.
- WIDTH=16, TAPS=16'hB400, OUT_W=4, SEED=16'hACE1:
  - 65535 entropy steps return state to 16'hACE1;
  - state is never 0 during the run.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types and constants for the dino-game LFSR random source.
package rng_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } rng_fsm_e;

    localparam int unsigned RNG_DEF_WIDTH = 5;
    localparam logic [4:0]  RNG_DEF_TAPS  = 5'b10010;
    localparam logic [4:0]  RNG_DEF_SEED  = 5'd1;

    // Maximal-length Fibonacci feedback masks (MSB always set).
    localparam logic [7:0]  RNG_TAPS_W8  = 8'hB8;
    localparam logic [15:0] RNG_TAPS_W16 = 16'hB400;
    localparam logic [31:0] RNG_TAPS_W32 = 32'h8020_0003;

endpackage : rng_pkg

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with seed load, step enable and zero-state recovery.
module lfsr_core #(
    parameter int unsigned      WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(5'b10010),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int unsigned      OUT_W = WIDTH
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic [OUT_W-1:0] draw_bits_c
);

    logic [WIDTH-1:0] next_c;

    // Shift left, feedback parity into bit 0; a zero state falls back to SEED.
    always_comb begin
        next_c = SEED;
        if (state != '0) begin
            next_c = {state[WIDTH-2:0], ^(state & TAPS)};
        end
    end

    assign draw_bits_c = next_c[OUT_W-1:0];

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= SEED;
        end else if (load) begin
            state <= (load_val == '0) ? SEED : load_val;
        end else if (step || (state == '0)) begin
            state <= next_c;
        end
    end

endmodule : lfsr_core

// File: rtl/lfsr_draw_rng.sv
// LFSR random source with entropy-gated free run and an OUT_W-bit request/valid draw port.
module lfsr_draw_rng
    import rng_pkg::*;
#(
    parameter int unsigned      WIDTH = RNG_DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(RNG_DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(RNG_DEF_SEED),
    parameter int unsigned      OUT_W = 5
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic             entropy_in,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             draw_req,
    output logic             draw_busy,
    output logic             draw_valid,
    output logic [OUT_W-1:0] draw_data,
    output logic [WIDTH-1:0] state
);

    localparam int unsigned CNT_W = $clog2(OUT_W + 1);

    rng_fsm_e         fsm;
    logic [CNT_W-1:0] cnt;
    logic             step_c;
    logic [OUT_W-1:0] draw_bits_c;

    // Draws step every edge; idle stepping follows entropy; seeding overrides both.
    assign step_c = !seed_load && ((fsm == DRAW) || entropy_in);

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED),
        .OUT_W (OUT_W)
    ) u_core (
        .clk         (clk),
        .sys_rst     (sys_rst),
        .step        (step_c),
        .load        (seed_load),
        .load_val    (seed_in),
        .state       (state),
        .draw_bits_c (draw_bits_c)
    );

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            fsm        <= IDLE;
            cnt        <= '0;
            draw_busy  <= 1'b0;
            draw_valid <= 1'b0;
            draw_data  <= '0;
        end else begin
            draw_valid <= 1'b0;
            if (seed_load) begin
                fsm       <= IDLE;
                cnt       <= '0;
                draw_busy <= 1'b0;
            end else begin
                case (fsm)
                    IDLE: begin
                        if (draw_req) begin
                            fsm       <= DRAW;
                            cnt       <= CNT_W'(OUT_W);
                            draw_busy <= 1'b1;
                        end
                    end
                    DRAW: begin
                        cnt <= cnt - CNT_W'(1);
                        // Last step: capture the bits this edge shifts in.
                        if (cnt == CNT_W'(1)) begin
                            fsm        <= IDLE;
                            draw_busy  <= 1'b0;
                            draw_valid <= 1'b1;
                            draw_data  <= draw_bits_c;
                        end
                    end
                    default: begin
                        fsm       <= IDLE;
                        cnt       <= '0;
                        draw_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : lfsr_draw_rng
